io_input_bank: RTL
==================

// Module: io_input_bank
// PURPOSE
//  Parametrised input-port bank for the CPU I/O space. Captures N_PORTS external
//  input words through a 2-flop synchroniser into holding registers. Per-port
//  sticky change flags feed a maskable interrupt. The CPU reads ports, status and
//  mask through the memory-mapped window at addr[7:2] = BASE_IDX onward.
// PARAMETERS
//  N_PORTS    4       number of input ports, 1..16
//  DATA_W     32      width of each port, 1..32; zero-extended on read
//  BASE_IDX   6'h30   word index (addr[7:2]) of port 0
//  DEB_CYCLES 4       debounce stability count, 1..255 (only with IO_DEBOUNCE_EN)
// PORTS
//  io_clk        in   1               single clock, all logic on rising edge
//  resetn        in   1               synchronous reset, active-low
//  addr          in   32              CPU address; only addr[7:2] decoded
//  rd_en         in   1               CPU read strobe (qualifies read-to-clear)
//  wr_en         in   1               CPU write strobe
//  wr_data       in   32              CPU write data
//  in_ports      in   N_PORTS*DATA_W  external inputs, port k at [k*DATA_W +: DATA_W]
//  io_read_data  out  32              read data, combinational from registers
//  irq           out  1               registered level interrupt
// BEHAVIOUR
//  Reset (resetn=0 at posedge): sync stages, in_reg[*], chg_flag, irq_mask, irq,
//   debounce counters -> 0. io_read_data then reads 0 at every address.
//  Capture path: sync1<=in_ports; sync2<=sync1; in_reg<=sync2 (see CONFIGURATION).
//   An input change is visible in in_reg 3 cycles after the edge at which it is sampled.
//  Change detect: when the in_reg[k] update value != current in_reg[k], set
//   chg_flag[k] in the same cycle in_reg[k] updates.
//  Address map (idx = addr[7:2]):
//   BASE_IDX+k, k<N_PORTS -> {zero-ext in_reg[k]}
//   BASE_IDX+N_PORTS      -> STATUS {zeros, chg_flag[N_PORTS-1:0]}
//   BASE_IDX+N_PORTS+1    -> MASK   {zeros, irq_mask[N_PORTS-1:0]}, read/write
//   anything else         -> 32'h0 (never holds the previous value; no latch)
//  Read-to-clear: rd_en=1 with idx=STATUS clears all chg_flag bits at next edge.
//   A flag being set in the same cycle as the clear wins: that bit stays 1.
//   Reading port data does not clear flags.
//  Writes: wr_en=1 with idx=MASK -> irq_mask<=wr_data[N_PORTS-1:0]. Writes to
//   any other index are ignored. rd_en and wr_en together: both take effect.
//  irq <= |(chg_flag & irq_mask), registered, so it lags flag/mask by 1 cycle.
//  Index arithmetic is 6-bit. Window must not wrap past 6'h3F; elaboration
//   rejects BASE_IDX+N_PORTS+1 > 63.
//  Reset mid-capture: in-flight sync values are discarded. No flag is raised
//   from the post-reset load of the first sample unless it differs from 0.
// CONFIGURATION
//  IO_DEBOUNCE_EN defined: per-port 8-bit counter cnt[k]. If sync2[k] != cand[k],
//   then cand[k]<=sync2[k] and cnt<=0. Otherwise, if cnt<DEB_CYCLES-1, cnt++.
//   When cnt reaches DEB_CYCLES-1 and cand[k] != in_reg[k], in_reg[k]<=cand[k]
//   and the flag is set. Total latency from the sampling edge is 3+DEB_CYCLES
//   cycles. Glitches shorter than DEB_CYCLES cycles never reach in_reg.
//  IO_DEBOUNCE_EN undefined: in_reg[k]<=sync2[k] every cycle. No counters exist.
// TESTING
//  1 Reset: hold resetn=0 for 2 cycles, in_ports=all 1s -> io_read_data=0 at every
//    index, irq=0.
//  2 Latency: N_PORTS=4. in_ports port2=32'hA5A5_0001 -> read idx 6'h32 returns
//    A5A5_0001 exactly 3 cycles later (3+DEB_CYCLES with the macro). STATUS=32'h4.
//  3 IRQ: write MASK (idx 6'h35) = 4'b0100, then change port2 -> irq rises 1 cycle
//    after the flag sets. Read STATUS with rd_en -> flag clears, irq falls next cycle.
//  4 Set vs clear collision: port0 change lands in the same cycle as the STATUS
//    read-clear -> STATUS bit0 remains 1 afterwards.
//  5 Unmapped/wrap: read idx 6'h00 and 6'h36 -> 32'h0. Write idx 6'h30 -> no
//    change to in_reg or mask. DATA_W=8 port reads as 32'h0000_00xx.
//  6 With IO_DEBOUNCE_EN and DEB_CYCLES=4: a 2-cycle pulse on port1 -> no flag, no
//    data change. A 6-cycle level on port1 -> updates and sets flag bit1.

Source files
------------

// File: rtl/io_input_bank.sv
// rtl/io_input_bank.sv - memory-mapped input port bank with sticky change flags and maskable irq
// Optional per-port debounce filter enabled by defining IO_DEBOUNCE_EN.
module io_input_bank #(
  parameter int          N_PORTS    = 4,
  parameter int          DATA_W     = 32,
  parameter logic [5:0]  BASE_IDX   = 6'h30,
  parameter int          DEB_CYCLES = 4
) (
  input  logic                      io_clk,
  input  logic                      resetn,
  input  logic [31:0]               addr,
  input  logic                      rd_en,
  input  logic                      wr_en,
  input  logic [31:0]               wr_data,
  input  logic [N_PORTS*DATA_W-1:0] in_ports,
  output logic [31:0]               io_read_data,
  output logic                      irq
);

  localparam int BASE_I   = int'(BASE_IDX);
  localparam int STATUS_I = BASE_I + N_PORTS;
  localparam int MASK_I   = STATUS_I + 1;

  generate
    if (MASK_I > 63 || N_PORTS < 1 || N_PORTS > 16 || DATA_W < 1 || DATA_W > 32 ||
        DEB_CYCLES < 1 || DEB_CYCLES > 255) begin : g_bad_params
      $error("io_input_bank: illegal parameters or register window wraps past 6'h3F");
    end
  endgenerate

  logic [N_PORTS*DATA_W-1:0] sync1_q, sync2_q;
  logic [DATA_W-1:0]         in_reg_q [N_PORTS];
  logic [DATA_W-1:0]         in_reg_d [N_PORTS];
  logic [N_PORTS-1:0]        chg_flag_q, chg_flag_d;
  logic [N_PORTS-1:0]        irq_mask_q, irq_mask_d;
  logic [N_PORTS-1:0]        set_flag;
  logic                      irq_q, irq_d;
  logic [5:0]                idx;
  logic                      is_status, is_mask;

`ifdef IO_DEBOUNCE_EN
  logic [DATA_W-1:0] cand_q [N_PORTS];
  logic [DATA_W-1:0] cand_d [N_PORTS];
  logic [7:0]        cnt_q  [N_PORTS];
  logic [7:0]        cnt_d  [N_PORTS];
`endif

  assign idx       = addr[7:2];
  assign is_status = (int'(idx) == STATUS_I);
  assign is_mask   = (int'(idx) == MASK_I);
  assign irq       = irq_q;

  logic unused_ok;
  assign unused_ok = &{1'b0, addr[31:8], addr[1:0], wr_data[31:N_PORTS]};

  always_comb begin
    io_read_data = '0;
    for (int k = 0; k < N_PORTS; k++) begin
      if (int'(idx) == BASE_I + k) io_read_data[DATA_W-1:0] = in_reg_q[k];
    end
    if (is_status) io_read_data[N_PORTS-1:0] = chg_flag_q;
    if (is_mask)   io_read_data[N_PORTS-1:0] = irq_mask_q;
  end

  always_comb begin
    set_flag = '0;
    for (int k = 0; k < N_PORTS; k++) begin
`ifdef IO_DEBOUNCE_EN
      cand_d[k]   = cand_q[k];
      cnt_d[k]    = cnt_q[k];
      in_reg_d[k] = in_reg_q[k];
      // Candidate must stay stable for DEB_CYCLES cycles before it is accepted.
      if (sync2_q[k*DATA_W +: DATA_W] != cand_q[k]) begin
        cand_d[k] = sync2_q[k*DATA_W +: DATA_W];
        cnt_d[k]  = 8'd0;
      end else if (cnt_q[k] < 8'(DEB_CYCLES - 1)) begin
        cnt_d[k] = cnt_q[k] + 8'd1;
      end
      if (cnt_q[k] == 8'(DEB_CYCLES - 1) && cand_q[k] != in_reg_q[k]) in_reg_d[k] = cand_q[k];
`else
      in_reg_d[k] = sync2_q[k*DATA_W +: DATA_W];
`endif
      set_flag[k] = (in_reg_d[k] != in_reg_q[k]);
    end
    // A flag set in the same cycle as the read-clear survives.
    chg_flag_d = ((rd_en && is_status) ? '0 : chg_flag_q) | set_flag;
    irq_mask_d = (wr_en && is_mask) ? wr_data[N_PORTS-1:0] : irq_mask_q;
    irq_d      = |(chg_flag_q & irq_mask_q);
  end

  always_ff @(posedge io_clk) begin
    if (!resetn) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      in_reg_q   <= '{default: '0};
      chg_flag_q <= '0;
      irq_mask_q <= '0;
      irq_q      <= 1'b0;
`ifdef IO_DEBOUNCE_EN
      cand_q     <= '{default: '0};
      cnt_q      <= '{default: '0};
`endif
    end else begin
      sync1_q    <= in_ports;
      sync2_q    <= sync1_q;
      in_reg_q   <= in_reg_d;
      chg_flag_q <= chg_flag_d;
      irq_mask_q <= irq_mask_d;
      irq_q      <= irq_d;
`ifdef IO_DEBOUNCE_EN
      cand_q     <= cand_d;
      cnt_q      <= cnt_d;
`endif
    end
  end

endmodule
